// File: rtl/threshold_voter_filt.sv
// ---------------------------------------------------------------------------
// threshold_voter_filt
//
// Registered K-of-N threshold voter with a persistence filter and per-channel
// fault tracking. Each valid cycle it samples N redundant votes. The raw vote
// is 1 when at least K votes are set. The filtered output y changes to a new
// raw value only after HOLD consecutive valid samples disagree with y.
// A channel is flagged faulty, and the flag stays set, once it has disagreed
// with the raw vote on FAULT_LIM consecutive valid samples.
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : the votes are sampled in this cycle
//   votes       : N redundant vote inputs
//   clr_faults  : synchronous clear of fault_mask and the disagreement counters
//   out_valid   : in_valid delayed by one cycle
//   count       : popcount of the last valid sample (held through invalid cycles)
//   y           : filtered vote output
//   fault_mask  : sticky per-channel fault flags
// ---------------------------------------------------------------------------
module threshold_voter_filt #(
  parameter int N         = 4,
  parameter int K         = 3,
  parameter int HOLD      = 2,
  parameter int FAULT_LIM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N-1:0]               votes,
  input  logic                       clr_faults,
  output logic                       out_valid,
  output logic [$clog2(N+1)-1:0]     count,
  output logic                       y,
  output logic [N-1:0]               fault_mask
);

  localparam int CNT_W  = $clog2(N+1);
  localparam int PEND_W = $clog2(HOLD+1);
  localparam int DIS_W  = $clog2(FAULT_LIM+1);

  typedef enum logic {ST_STABLE, ST_PENDING} state_t;

  logic [CNT_W-1:0]  w_popcount;
  logic              w_raw;

  logic              r_out_valid;
  logic [CNT_W-1:0]  r_count;
  logic              r_y;
  logic              w_y_next;
  state_t            r_state;
  state_t            w_state_next;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_next;
  logic [N-1:0]      w_fault_mask;

  // Popcount of the current votes and the unfiltered threshold decision.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < N; i++) begin
      w_popcount = w_popcount + CNT_W'(votes[i]);
    end
  end

  assign w_raw = (w_popcount >= CNT_W'(K));

  // Sample register: out_valid follows in_valid; count holds between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_count <= w_popcount;
      end
    end
  end

  // Persistence filter: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_pend  <= '0;
      r_y     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_y     <= w_y_next;
    end
  end

  // Persistence filter: next-state logic. Invalid cycles leave everything as is.
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_y_next     = r_y;
    case (r_state)
      ST_STABLE: begin
        if (in_valid && (w_raw != r_y)) begin
          if (HOLD == 1) begin
            // A single disagreeing sample is enough; no pending phase.
            w_y_next = w_raw;
          end else begin
            w_pend_next  = PEND_W'(1);
            w_state_next = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (in_valid) begin
          if (w_raw == r_y) begin
            w_pend_next  = '0;
            w_state_next = ST_STABLE;
          end else if (r_pend == PEND_W'(HOLD-1)) begin
            w_y_next     = w_raw;
            w_pend_next  = '0;
            w_state_next = ST_STABLE;
          end else begin
            w_pend_next = r_pend + PEND_W'(1);
          end
        end
      end
      default: begin
        w_pend_next  = '0;
        w_state_next = ST_STABLE;
      end
    endcase
  end

  // Per-channel disagreement counter and sticky fault flag. Channels are
  // compared against the raw vote so the filter delay does not skew them.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      logic [DIS_W-1:0] r_dis;
      logic             r_fault;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dis   <= '0;
          r_fault <= 1'b0;
        end else if (clr_faults) begin
          // Clear takes priority over a coincident increment or set.
          r_dis   <= '0;
          r_fault <= 1'b0;
        end else if (in_valid) begin
          if (votes[gi] != w_raw) begin
            if (r_dis != DIS_W'(FAULT_LIM)) begin
              r_dis <= r_dis + DIS_W'(1);
            end
            // The counter reaches the limit on this edge, so set the flag now.
            if (r_dis >= DIS_W'(FAULT_LIM-1)) begin
              r_fault <= 1'b1;
            end
          end else begin
            r_dis <= '0;
          end
        end
      end

      assign w_fault_mask[gi] = r_fault;
    end
  endgenerate

  assign out_valid  = r_out_valid;
  assign count      = r_count;
  assign y          = r_y;
  assign fault_mask = w_fault_mask;

endmodule

// File: tb/tb_threshold_voter_filt.sv
`timescale 1ns/100ps
module tb_threshold_voter_filt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] votes = 4'b0000;
  logic       clr_faults = 1'b0;

  logic       ov_a, ov_b, ov_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic       y_a, y_b, y_c;
  logic [3:0] fm_a, fm_b, fm_c;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  // Three configurations driven by the same stimulus:
  //   a: K=3 HOLD=1   b: K=3 HOLD=3   c: K=4 (unanimity) HOLD=2
  threshold_voter_filt #(.N(4), .K(3), .HOLD(1), .FAULT_LIM(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes), .clr_faults(clr_faults),
    .out_valid(ov_a), .count(cnt_a), .y(y_a), .fault_mask(fm_a));
  threshold_voter_filt #(.N(4), .K(3), .HOLD(3), .FAULT_LIM(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes), .clr_faults(clr_faults),
    .out_valid(ov_b), .count(cnt_b), .y(y_b), .fault_mask(fm_b));
  threshold_voter_filt #(.N(4), .K(4), .HOLD(2), .FAULT_LIM(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .votes(votes), .clr_faults(clr_faults),
    .out_valid(ov_c), .count(cnt_c), .y(y_c), .fault_mask(fm_c));

  // ---------------- behavioural model ----------------
  // y flips once the most recent HOLD valid raw decisions all differ from y.
  // A channel faults once its run of disagreements with raw reaches the limit.
  localparam int KS[3] = '{3, 3, 4};
  localparam int HS[3] = '{1, 3, 2};
  localparam int FLIM  = 4;

  logic       m_ov[3];
  logic [2:0] m_cnt[3];
  logic       m_y[3];
  logic [3:0] m_mask[3];
  logic [7:0] m_hist[3];
  int         m_nv[3];
  int         m_streak[3][4];

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_ov[c] = 1'b0; m_cnt[c] = 3'd0; m_y[c] = 1'b0; m_mask[c] = 4'b0;
      m_hist[c] = 8'd0; m_nv[c] = 0;
      for (int i = 0; i < 4; i++) m_streak[c][i] = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        for (int c = 0; c < 3; c++) begin
          int  pc;
          bit  raw;
          bit  all_diff;
          m_ov[c] = in_valid;
          if (in_valid) begin
            pc = $countones(votes);
            raw = (pc >= KS[c]);
            m_cnt[c] = 3'(pc);
            m_hist[c] = {m_hist[c][6:0], raw};
            if (m_nv[c] < 100) m_nv[c]++;
            all_diff = (m_nv[c] >= HS[c]);
            for (int j = 0; j < HS[c]; j++)
              if (m_hist[c][j] == m_y[c]) all_diff = 1'b0;
            if (all_diff) m_y[c] = raw;
            for (int i = 0; i < 4; i++) begin
              if (votes[i] != raw) m_streak[c][i]++;
              else m_streak[c][i] = 0;
              if (m_streak[c][i] >= FLIM) m_mask[c][i] = 1'b1;
            end
          end
          if (clr_faults) begin
            m_mask[c] = 4'b0;
            for (int i = 0; i < 4; i++) m_streak[c][i] = 0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    wait (chk_en);
    forever begin
      @(posedge clk);
      #2;
      chk("a_out_valid", 32'(ov_a), 32'(m_ov[0]));
      chk("a_count",     32'(cnt_a), 32'(m_cnt[0]));
      chk("a_y",         32'(y_a), 32'(m_y[0]));
      chk("a_fault",     32'(fm_a), 32'(m_mask[0]));
      chk("b_out_valid", 32'(ov_b), 32'(m_ov[1]));
      chk("b_count",     32'(cnt_b), 32'(m_cnt[1]));
      chk("b_y",         32'(y_b), 32'(m_y[1]));
      chk("b_fault",     32'(fm_b), 32'(m_mask[1]));
      chk("c_out_valid", 32'(ov_c), 32'(m_ov[2]));
      chk("c_count",     32'(cnt_c), 32'(m_cnt[2]));
      chk("c_y",         32'(y_c), 32'(m_y[2]));
      chk("c_fault",     32'(fm_c), 32'(m_mask[2]));
    end
  end

  // One transaction: drive on the falling edge, return just after the rising
  // edge that samples it, so outputs then reflect this transaction.
  task automatic cyc(input logic v, input logic [3:0] vt, input logic clr);
    @(negedge clk);
    in_valid = v; votes = vt; clr_faults = clr;
    @(posedge clk);
    #3;
    $display("[TB] v=%0b votes=%b clr=%0b | a:y=%0b cnt=%0d fm=%b | b:y=%0b cnt=%0d fm=%b | c:y=%0b cnt=%0d fm=%b",
             v, vt, clr, y_a, cnt_a, fm_a, y_b, cnt_b, fm_b, y_c, cnt_c, fm_c);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_a_y", 32'(y_a), 0);
    chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_a_ov", 32'(ov_a), 0);
    chk("rst_b_fault", 32'(fm_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic K-of-N with HOLD=1
    cyc(1'b1, 4'b0111, 1'b0);
    chk("t1_a_count3", 32'(cnt_a), 3);
    chk("t1_a_y1", 32'(y_a), 1);
    cyc(1'b1, 4'b0011, 1'b0);
    chk("t1_a_count2", 32'(cnt_a), 2);
    chk("t1_a_y0", 32'(y_a), 0);

    // HOLD=3: interrupted run does not flip; gapped run of three does
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    chk("t2_b_interrupted", 32'(y_b), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    chk("t2_b_ov_gap", 32'(ov_b), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    chk("t2_b_count_held", 32'(cnt_b), 4);
    chk("t2_b_not_yet", 32'(y_b), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t2_b_flip", 32'(y_b), 1);

    // Fault tracking
    cyc(1'b0, 4'b0000, 1'b1);
    repeat (3) cyc(1'b1, 4'b1110, 1'b0);
    chk("t3_a_mask_3rd", 32'(fm_a), 0);
    cyc(1'b1, 4'b1110, 1'b0);
    chk("t3_a_mask_4th", 32'(fm_a), 32'h1);
    chk("t3_c_mask_4th", 32'(fm_c), 32'he);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t3_a_sticky", 32'(fm_a), 32'h1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("t3_a_cleared", 32'(fm_a), 0);

    // Unanimity (dut_c): 3 of 4 is not enough
    cyc(1'b1, 4'b1110, 1'b0);
    cyc(1'b1, 4'b1110, 1'b0);
    chk("t4_c_count3", 32'(cnt_c), 3);
    chk("t4_c_y0", 32'(y_c), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t4_c_one", 32'(y_c), 0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t4_c_flip", 32'(y_c), 1);

    // Clear beats a coincident increment
    cyc(1'b0, 4'b0000, 1'b1);
    repeat (3) cyc(1'b1, 4'b1110, 1'b0);
    cyc(1'b1, 4'b1110, 1'b1);
    chk("t6_clr_wins", 32'(fm_a), 0);
    repeat (3) cyc(1'b1, 4'b1110, 1'b0);
    chk("t6_restart", 32'(fm_a), 0);
    cyc(1'b1, 4'b1110, 1'b0);
    chk("t6_refault", 32'(fm_a), 32'h1);

    // Asynchronous reset in the middle of a pending flip
    repeat (3) cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t5_a_y_before", 32'(y_a), 1);
    chk("t5_b_pending", 32'(y_b), 0);
    #1 rst_n = 1'b0;
    #0.5;
    chk("t5_a_y_async", 32'(y_a), 0);
    chk("t5_a_count_async", 32'(cnt_a), 0);
    chk("t5_a_ov_async", 32'(ov_a), 0);
    chk("t5_a_fault_async", 32'(fm_a), 0);
    cyc(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t5_b_discarded", 32'(y_b), 0);
    chk("t5_a_after", 32'(y_a), 1);

    // Mixed traffic, checked by the model every cycle
    for (int n = 0; n < 40; n++) begin
      logic       v;
      logic [3:0] vt;
      logic       cl;
      v  = ($urandom_range(0, 3) != 0);
      vt = 4'($urandom_range(0, 15));
      cl = ($urandom_range(0, 9) == 0);
      cyc(v, vt, cl);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
